// File: rtl/rd_pipe.sv
// Two-stage reward decider: per-road table lookup, then a saturating sum across roads.
// Valid/ready handshaking with a global stall, plus a saturating episode accumulator.
module rd_pipe #(
    parameter int N_ROAD    = 4,
    parameter int L_WIDTH   = 4,
    parameter int LVL_BITS  = 2,
    parameter int R_WIDTH   = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_ROAD*L_WIDTH-1:0]         L,
    input  logic                              cfg_we,
    input  logic [LVL_BITS-1:0]               cfg_addr,
    input  logic [R_WIDTH-1:0]                cfg_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [R_WIDTH-1:0]         R,
    output logic                              R_sat,
    input  logic                              acc_clr,
    output logic signed [ACC_WIDTH-1:0]       acc
);

    localparam int unsigned DEPTH = 1 << LVL_BITS;
    localparam int unsigned SW    = R_WIDTH + $clog2(N_ROAD);

    // Default rewards (+100, 0, -100, -128 in Q.8), clamped to R_WIDTH; higher entries most-negative.
    function automatic logic [R_WIDTH-1:0] tbl_default(input int unsigned idx);
        longint hi;
        longint lo;
        longint v;
        hi = (longint'(1) <<< (R_WIDTH - 1)) - 1;
        lo = -hi - 1;
        case (idx)
            0:       v = 25600;
            1:       v = 0;
            2:       v = -25600;
            3:       v = -32768;
            default: v = lo;
        endcase
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v[R_WIDTH-1:0];
    endfunction

    logic [R_WIDTH-1:0]  tbl    [DEPTH];
    logic [LVL_BITS-1:0] lvl    [N_ROAD];
    logic [R_WIDTH-1:0]  s1_rew [N_ROAD];
    logic                s1_valid;
    logic                en;
    logic                hs;
    logic [SW-1:0]       sum;
    logic                fits;
    logic [R_WIDTH-1:0]  sum_sat;
    logic [ACC_WIDTH:0]  r_ext;
    logic [ACC_WIDTH:0]  acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                unused_code_bits;

    assign unused_code_bits = ^L;

    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
        hs       = out_valid && out_ready;
    end

    always_comb begin
        for (int unsigned i = 0; i < N_ROAD; i++)
            lvl[i] = L[i*L_WIDTH + (L_WIDTH - LVL_BITS) +: LVL_BITS];
    end

    // Lookups read the pre-edge table, so a same-cycle write is seen only by later samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++)
                tbl[k] <= tbl_default(k);
        end else if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int unsigned i = 0; i < N_ROAD; i++)
                s1_rew[i] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int unsigned i = 0; i < N_ROAD; i++)
                    s1_rew[i] <= tbl[lvl[i]];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N_ROAD; i++)
            sum = sum + {{(SW-R_WIDTH){s1_rew[i][R_WIDTH-1]}}, s1_rew[i]};
        // The sum fits iff every bit above the R_WIDTH sign position matches it.
        fits    = (~|sum[SW-1:R_WIDTH-1]) || (&sum[SW-1:R_WIDTH-1]);
        sum_sat = sum[SW-1] ? {1'b1, {(R_WIDTH-1){1'b0}}} : {1'b0, {(R_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            R         <= '0;
            R_sat     <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                R     <= fits ? sum[R_WIDTH-1:0] : sum_sat;
                R_sat <= !fits;
            end
        end
    end

    always_comb begin
        r_ext    = {{(ACC_WIDTH+1-R_WIDTH){R[R_WIDTH-1]}}, R};
        acc_sum  = {acc[ACC_WIDTH-1], acc} + r_ext;
        acc_next = acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
            acc_next = acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (acc_clr)
            acc <= hs ? r_ext[ACC_WIDTH-1:0] : '0;
        else if (hs)
            acc <= acc_next;
    end

endmodule

// File: tb/tb_rd_pipe.sv
// Bench for rd_pipe: queue-based reward model with per-cycle compare, plus directed literal checks.
module tb_rd_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        L = '0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [15:0]        cfg_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] R;
    logic               R_sat;
    logic               acc_clr = 1'b0;
    logic signed [31:0] acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rd_pipe #(.N_ROAD(4), .L_WIDTH(4), .LVL_BITS(2), .R_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .L(L),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .R(R), .R_sat(R_sat),
        .acc_clr(acc_clr), .acc(acc)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model state: reward table, in-order queue of expected results, accumulator.
    int     tbl_m [4];
    longint q_r [$];
    bit     q_s [$];
    longint acc_m;

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic void model_lookup(input logic [15:0] codes, output longint r, output bit s);
        longint total;
        logic [3:0] c;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            c = codes[i*4 +: 4];
            total += tbl_m[int'(c) / 4];
        end
        r = clamp(total, -32768, 32767);
        s = (r != total);
    endfunction

    always @(negedge clk) begin
        longint er;
        bit     es;
        longint popped;
        bit     hs;
        #2;
        if (rst) begin
            tbl_m[0] = 25600; tbl_m[1] = 0; tbl_m[2] = -25600; tbl_m[3] = -32768;
            q_r.delete(); q_s.delete();
            acc_m = 0;
        end else begin
            chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
            chk("acc", acc, acc_m);
            if (out_valid) begin
                if (q_r.size() == 0) chk("spurious_out_valid", longint'(out_valid), 0);
                else begin
                    chk("R", R, q_r[0]);
                    chk("R_sat", longint'(R_sat), longint'(q_s[0]));
                end
            end
            // Effects of the coming clock edge.
            hs = out_valid && out_ready && (q_r.size() > 0);
            popped = 0;
            if (hs) begin
                popped = q_r.pop_front();
                void'(q_s.pop_front());
            end
            if (in_valid && in_ready) begin
                model_lookup(L, er, es);
                q_r.push_back(er); q_s.push_back(es);
            end
            if (cfg_we) tbl_m[cfg_addr] = int'($signed(cfg_data));
            if (acc_clr) acc_m = hs ? popped : 0;
            else if (hs) acc_m = clamp(acc_m + popped, -64'sd2147483648, 64'sd2147483647);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] codes);
        in_valid = 1'b1;
        L = codes;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input longint er, input longint es);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({name, "_timeout"}, longint'(out_valid), 1);
        else begin
            chk(name, R, er);
            chk({name, "_sat"}, longint'(R_sat), es);
        end
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_R", R, 0);
        chk("rst_R_sat", longint'(R_sat), 0);
        chk("rst_acc", acc, 0);

        // Levels (0,1,2,1): latency exactly two cycles from acceptance.
        send(16'h4840);
        chk("lat_cycle1_out_valid", longint'(out_valid), 0);
        cyc();
        chk("lat_cycle2_out_valid", longint'(out_valid), 1);
        chk("T1_R", R, 0);
        chk("T1_sat", longint'(R_sat), 0);
        cyc();

        send(16'h4440); wait_out("T2_R", 25600, 0); cyc();
        send(16'h0000); wait_out("T3_R", 32767, 1); cyc();
        send(16'hCCCC); wait_out("T4_R", -32768, 1); cyc();
        send(16'hF7B3); wait_out("T5_R_exact_min", -32768, 0); cyc();

        // Table write coincident with lookup of the same entry.
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 16'h0100;
        in_valid = 1'b1; L = 16'h4444;
        cyc();
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_out("W_old_R", 0, 0); cyc();
        send(16'h4444); wait_out("W_new_R", 1024, 0); cyc();
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 16'h0000;
        cyc();
        cfg_we = 1'b0;

        // Back-to-back samples into a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1;
        L = 16'h4440; cyc();
        L = 16'h8888; cyc();
        L = 16'h0000; cyc();
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_out_valid", longint'(out_valid), 1);
            chk("stall_R_held", R, 25600);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("stall_all_delivered", q_r.size(), 0);

        // Episode accumulator.
        acc_clr = 1'b1; cyc(); acc_clr = 1'b0;
        chk("acc_clr_idle", acc, 0);
        for (int i = 0; i < 4; i++) begin
            send(16'h4440); wait_out("acc_in_R", 25600, 0); cyc();
        end
        chk("acc_four", acc, 102400);
        send(16'h4448);
        wait_out("acc5_R", -25600, 0);
        acc_clr = 1'b1;
        cyc();
        acc_clr = 1'b0;
        chk("acc_clr_with_hs", acc, -25600);

        // Reset with both stages full and a modified table.
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 16'hFF00;
        cyc();
        cfg_we = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        L = 16'h4440; cyc();
        L = 16'h0000; cyc();
        in_valid = 1'b0;
        chk("pre_rst_out_valid", longint'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", longint'(out_valid), 0);
        chk("async_rst_acc", acc, 0);
        chk("async_rst_R", R, 0);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        cyc();
        send(16'h0000); wait_out("rst_tbl_default_R", 32767, 1); cyc();
        repeat (3) cyc();
        chk("end_queue_empty", q_r.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
